// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arbiter
//  Description : Round-robin arbiter sharing one FIFO write port between
//                NUM_REQ valid/ready producers, with bounded bursts per grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_wr_en,
    output logic [WIDTH-1:0]           fifo_data_in,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int SW  = IDW + 1;
    localparam int CW  = $clog2(MAX_BURST + 1);

    localparam logic [0:0]     c_idle      = 1'b0;
    localparam logic [0:0]     c_grant     = 1'b1;
    localparam logic [CW-1:0]  c_last_beat = CW'(MAX_BURST - 1);
    localparam logic [IDW-1:0] c_last_id   = IDW'(NUM_REQ - 1);
    localparam logic [SW-1:0]  c_num_req   = SW'(NUM_REQ);

    logic [0:0]     r_state;
    logic [IDW-1:0] r_grant_id;
    logic [IDW-1:0] r_rr_ptr;
    logic [CW-1:0]  r_burst_cnt;

    logic [0:0]     w_state_nxt;
    logic [IDW-1:0] w_grant_id_nxt;
    logic [IDW-1:0] w_rr_ptr_nxt;
    logic [CW-1:0]  w_burst_cnt_nxt;

    logic [WIDTH-1:0] w_data [NUM_REQ];
    logic [IDW-1:0]   w_next_ptr;
    logic [IDW-1:0]   w_scan_ptr;
    logic [IDW-1:0]   w_winner;
    logic             w_found;
    logic [SW-1:0]    w_sum;
    logic             w_beat;
    logic             w_release;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_data[gi] = req_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign w_next_ptr = (r_grant_id == c_last_id) ? '0 : r_grant_id + IDW'(1);

    // A release rescans from the slot after the holder, so the holder is the
    // last candidate; in IDLE the stored pointer already holds that value.
    assign w_scan_ptr = (r_state == c_grant) ? w_next_ptr : r_rr_ptr;

    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, w_scan_ptr} + SW'(k);
            if (w_sum >= c_num_req) begin
                w_sum = w_sum - c_num_req;
            end
            if (!w_found && req_valid[w_sum[IDW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[IDW-1:0];
            end
        end
    end

    assign w_beat    = (r_state == c_grant) && req_valid[r_grant_id] && !fifo_full;
    assign w_release = (r_state == c_grant) &&
                       ((w_beat && (r_burst_cnt == c_last_beat)) || !req_valid[r_grant_id]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_idle;
            r_grant_id  <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant_id  <= w_grant_id_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_grant_id_nxt  = r_grant_id;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_burst_cnt_nxt = r_burst_cnt;
        case (r_state)
            c_idle: begin
                if (w_found) begin
                    w_state_nxt     = c_grant;
                    w_grant_id_nxt  = w_winner;
                    w_burst_cnt_nxt = '0;
                end
            end
            c_grant: begin
                if (w_release) begin
                    w_rr_ptr_nxt = w_next_ptr;
                    if (w_found) begin
                        w_grant_id_nxt  = w_winner;
                        w_burst_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = c_idle;
                    end
                end else if (w_beat) begin
                    w_burst_cnt_nxt = r_burst_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = c_idle;
            end
        endcase
    end

    always_comb begin
        grant_valid  = (r_state == c_grant);
        fifo_wr_en   = w_beat;
        fifo_data_in = w_data[r_grant_id];
        req_ready    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            req_ready[k] = (r_state == c_grant) && (r_grant_id == IDW'(k)) && !fifo_full;
        end
    end

    assign grant_id = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_wr_arbiter
//  Description : Scoreboard bench for fifo_wr_arbiter, MAX_BURST=4 and =1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic           fifo_full;

    logic [N-1:0] rdy0, rdy1;
    logic         wr0, wr1;
    logic [W-1:0] dat0, dat1;
    logic         gv0, gv1;
    logic [1:0]   gid0, gid1;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(4)) u_dut_b4 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rdy0), .fifo_full(fifo_full), .fifo_wr_en(wr0),
        .fifo_data_in(dat0), .grant_valid(gv0), .grant_id(gid0)
    );

    fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(1)) u_dut_b1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rdy1), .fifo_full(fifo_full), .fifo_wr_en(wr1),
        .fifo_data_in(dat1), .grant_valid(gv1), .grant_id(gid1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int ctrl_q0[$], ctrl_q1[$], beat_q0[$], beat_q1[$];

    // Reference state: who holds the write port (-1 = nobody), beats taken
    // under this grant, where the next rotation search starts, last holder.
    int owner[2], beats[2], ptr[2], last_gid[2];
    int mb[2];
    logic [N-1:0] last_rdy0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int from);
        for (int k = 0; k < N; k++) begin
            if (v[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        mb[0] = 4;
        mb[1] = 1;
        for (int k = 0; k < 2; k++) begin
            owner[k]    = -1;
            beats[k]    = 0;
            ptr[k]      = 0;
            last_gid[k] = 0;
        end
    endtask

    // Expected outputs for this cycle's inputs, then advance to the next edge.
    task automatic model_cycle(input int k, output int ctrl, output int bt, output bit is_beat);
        int           gid;
        int           w;
        bit           gv;
        logic [N-1:0] rdy;
        gid = last_gid[k];
        gv  = 1'b0;
        rdy = '0;
        is_beat = 1'b0;
        if (owner[k] >= 0) begin
            gv  = 1'b1;
            gid = owner[k];
            rdy = fifo_full ? '0 : (N'(1) << gid);
            is_beat = req_valid[gid] && !fifo_full;
        end
        ctrl = (int'(gv) << 7) | (gid << 5) | (int'(rdy) << 1) | int'(is_beat);
        bt   = (gid << 8) | int'(req_data[gid*W +: W]);

        if (owner[k] < 0) begin
            w = pick(req_valid, ptr[k]);
            if (w >= 0) begin
                owner[k]    = w;
                beats[k]    = 0;
                last_gid[k] = w;
            end
        end else begin
            if (is_beat) beats[k]++;
            if ((is_beat && beats[k] == mb[k]) || !req_valid[owner[k]]) begin
                ptr[k]   = (owner[k] + 1) % N;
                w        = pick(req_valid, ptr[k]);
                owner[k] = w;
                beats[k] = 0;
                if (w >= 0) last_gid[k] = w;
            end
        end
    endtask

    task automatic step();
        int ctrl;
        int bt;
        bit b;
        model_cycle(0, ctrl, bt, b);
        ctrl_q0.push_back(ctrl);
        if (b) beat_q0.push_back(bt);
        last_rdy0 = ctrl[4:1];
        model_cycle(1, ctrl, bt, b);
        ctrl_q1.push_back(ctrl);
        if (b) beat_q1.push_back(bt);
    endtask

    // mode 0: random, 1: all valid, 2: only req 0, 3: reqs 0 and 2
    task automatic gen(input int mode);
        logic [N-1:0] pv;
        logic [N-1:0] mask;
        pv   = req_valid;
        mask = (mode == 2) ? 4'b0001 : (mode == 3) ? 4'b0101 : 4'b1111;
        for (int i = 0; i < N; i++) begin
            bool_hold: begin
                if (pv[i] && !last_rdy0[i] && mask[i]) begin
                    if (mode == 0 && $urandom_range(0, 9) == 0) req_valid[i] = 1'b0;
                end else begin
                    req_valid[i] = mask[i] && ((mode != 0) || ($urandom_range(0, 3) != 0));
                    req_data[i*W +: W] = W'($urandom_range(0, 255));
                end
            end
        end
        fifo_full = (mode == 0) && ($urandom_range(0, 4) == 0);
    endtask

    task automatic run_phase(input int mode, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            gen(mode);
            step();
        end
    endtask

    int e_val;
    always @(negedge clk) begin
        if (rst_n) begin
            if (ctrl_q0.size() == 0) begin
                chk("ctrl_q_b4_empty", 1, 0);
            end else begin
                e_val = ctrl_q0.pop_front();
                chk("ctrl_b4", (int'(gv0) << 7) | (int'(gid0) << 5) | (int'(rdy0) << 1) | int'(wr0), e_val);
            end
            if (ctrl_q1.size() == 0) begin
                chk("ctrl_q_b1_empty", 1, 0);
            end else begin
                e_val = ctrl_q1.pop_front();
                chk("ctrl_b1", (int'(gv1) << 7) | (int'(gid1) << 5) | (int'(rdy1) << 1) | int'(wr1), e_val);
            end
            if (wr0) begin
                if (beat_q0.size() == 0) chk("unexpected_beat_b4", 1, 0);
                else begin
                    e_val = beat_q0.pop_front();
                    chk("beat_b4", (int'(gid0) << 8) | int'(dat0), e_val);
                end
            end
            if (wr1) begin
                if (beat_q1.size() == 0) chk("unexpected_beat_b1", 1, 0);
                else begin
                    e_val = beat_q1.pop_front();
                    chk("beat_b1", (int'(gid1) << 8) | int'(dat1), e_val);
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = 32'hC3A5_5A3C;
        fifo_full = 1'b0;
        last_rdy0 = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        req_valid = 4'b1111;
        #1;
        chk("rst_gv_b4", int'(gv0), 0);
        chk("rst_wr_b4", int'(wr0), 0);
        chk("rst_rdy_b4", int'(rdy0), 0);
        chk("rst_gid_b4", int'(gid0), 0);
        chk("rst_data_b4", int'(dat0), 32'h3C);
        chk("rst_gv_b1", int'(gv1), 0);
        chk("rst_rdy_b1", int'(rdy1), 0);
        req_valid = '0;

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        run_phase(2, 10);
        run_phase(1, 24);
        run_phase(3, 12);
        run_phase(0, 1500);
        run_phase(1, 7);

        // Asynchronous reset in the middle of a live burst.
        @(posedge clk);
        #1;
        req_valid = 4'b1001;
        fifo_full = 1'b0;
        #1;
        chk("pre_rst_gv_b4", int'(gv0), int'(owner[0] >= 0));
        rst_n = 1'b0;
        #1;
        chk("async_gv_b4", int'(gv0), 0);
        chk("async_wr_b4", int'(wr0), 0);
        chk("async_rdy_b4", int'(rdy0), 0);
        chk("async_gid_b4", int'(gid0), 0);
        chk("async_gv_b1", int'(gv1), 0);
        chk("async_wr_b1", int'(wr1), 0);
        model_reset();
        last_rdy0 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        @(posedge clk);
        #2;
        chk("post_rst_first_gid_b4", int'(gid0), 0);
        step();

        run_phase(0, 1500);
        run_phase(3, 10);

        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            req_valid = '0;
            fifo_full = 1'b0;
            step();
        end
        @(negedge clk);
        #1;
        chk("leftover_beats_b4", beat_q0.size(), 0);
        chk("leftover_beats_b1", beat_q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
